// File: rtl/tristate_bus_reader.sv
// tristate_bus_reader: selects one tri-state bus driver, waits for settle, double-samples
// the bus and returns a stable word, retrying on sample mismatch until an error limit.
module tristate_bus_reader #(
  parameter int WIDTH       = 8,
  parameter int N_DEV       = 4,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_RETRY   = 3,
  localparam int DW = N_DEV > 1 ? $clog2(N_DEV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req,
  input  logic [DW-1:0]    rd_dev,
  input  logic [WIDTH-1:0] bus_in,
  output logic [N_DEV-1:0] dev_en,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             rd_err
);
  localparam int WW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  typedef enum logic [2:0] {IDLE, ENABLE, SAMPLE1, SAMPLE2, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [DW-1:0] dev, dev_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic [WIDTH-1:0] s1, s1_nx, data_nx;
  always_comb begin
    state_nx = state;
    dev_nx = dev;
    wcnt_nx = wcnt;
    rcnt_nx = rcnt;
    s1_nx = s1;
    data_nx = data_out;
    case (state)
      IDLE: if (rd_req) begin
        dev_nx = rd_dev;
        rcnt_nx = '0;
        wcnt_nx = WW'(WAIT_CYCLES - 1);
        state_nx = 32'(rd_dev) < N_DEV ? ENABLE : ERR;
      end
      ENABLE: begin
        wcnt_nx = wcnt == '0 ? wcnt : wcnt - 1'b1;
        state_nx = wcnt == '0 ? SAMPLE1 : ENABLE;
      end
      SAMPLE1: begin
        s1_nx = bus_in;
        state_nx = SAMPLE2;
      end
      SAMPLE2: if (bus_in == s1) begin
        data_nx = s1;
        state_nx = DONE;
      end else if (32'(rcnt) < MAX_RETRY) begin
        rcnt_nx = rcnt + 1'b1;
        wcnt_nx = WW'(WAIT_CYCLES - 1);
        state_nx = ENABLE;
      end else begin
        state_nx = ERR;
      end
      default: state_nx = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dev <= '0;
      wcnt <= '0;
      rcnt <= '0;
      s1 <= '0;
      data_out <= '0;
      dev_en <= '0;
      busy <= 1'b0;
      data_valid <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      state <= state_nx;
      dev <= dev_nx;
      wcnt <= wcnt_nx;
      rcnt <= rcnt_nx;
      s1 <= s1_nx;
      data_out <= data_nx;
      dev_en <= state_nx inside {ENABLE, SAMPLE1, SAMPLE2} ? N_DEV'(1) << dev_nx : '0;
      busy <= state_nx != IDLE;
      data_valid <= state_nx == DONE;
      rd_err <= state_nx == ERR;
    end
  end
endmodule

// File: tb/tb_tristate_bus_reader.sv
// tb_tristate_bus_reader: randomized bench with a per-attempt reference model of the read protocol.
module tb_tristate_bus_reader;
  localparam int WC = 2;
  localparam int MR = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic rd_req = 1'b0;
  logic [1:0] rd_dev = '0;
  logic [7:0] bus_in = '0;
  logic [3:0] dev_en;
  logic busy, data_valid, rd_err;
  logic [7:0] data_out;
  logic rd_req3 = 1'b0;
  logic [1:0] rd_dev3 = '0;
  logic [7:0] bus3 = '0;
  logic [2:0] dev_en3;
  logic busy3, data_valid3, rd_err3;
  logic [7:0] data_out3;
  int tests = 0;
  int fails = 0;
  logic [7:0] pat[32];
  logic [7:0] prev_data = '0;

  tristate_bus_reader #(.WIDTH(8), .N_DEV(4), .WAIT_CYCLES(WC), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_dev(rd_dev), .bus_in(bus_in),
    .dev_en(dev_en), .busy(busy), .data_out(data_out), .data_valid(data_valid), .rd_err(rd_err));

  tristate_bus_reader #(.WIDTH(8), .N_DEV(3), .WAIT_CYCLES(WC), .MAX_RETRY(MR)) dut3 (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req3), .rd_dev(rd_dev3), .bus_in(bus3),
    .dev_en(dev_en3), .busy(busy3), .data_out(data_out3), .data_valid(data_valid3), .rd_err(rd_err3));

  // A read is a series of attempts; attempt k samples the bus W and W+1 cycles into its window
  // of W+2 cycles. The first attempt with equal samples wins, otherwise the read fails.
  task automatic run_read(input logic [1:0] dev, input bit hold_req, input string name);
    int e;
    bit ok;
    logic [7:0] d;
    logic [3:0] exp_en;
    ok = 1'b0;
    d = prev_data;
    e = 1 + (MR + 1) * (WC + 2);
    for (int k = MR; k >= 0; k--)
      if (pat[k * (WC + 2) + WC] == pat[k * (WC + 2) + WC + 1]) begin
        ok = 1'b1;
        d = pat[k * (WC + 2) + WC];
        e = 1 + (k + 1) * (WC + 2);
      end
    @(negedge clk);
    rd_req = 1'b1;
    rd_dev = dev;
    bus_in = 8'($urandom);
    for (int n = 1; n <= e + 1; n++) begin
      @(negedge clk);
      rd_req = hold_req && n < e;
      if (hold_req) rd_dev = 2'd1;
      exp_en = n < e ? 4'b0001 << dev : 4'b0000;
      tests += 5;
      if (dev_en !== exp_en) begin
        fails++;
        $display("FAIL %s dev_en edge %0d: got %b want %b", name, n, dev_en, exp_en);
      end
      if (busy !== (n <= e)) begin
        fails++;
        $display("FAIL %s busy edge %0d: got %b want %b", name, n, busy, n <= e);
      end
      if (data_valid !== (n == e && ok)) begin
        fails++;
        $display("FAIL %s data_valid edge %0d: got %b want %b", name, n, data_valid, n == e && ok);
      end
      if (rd_err !== (n == e && !ok)) begin
        fails++;
        $display("FAIL %s rd_err edge %0d: got %b want %b", name, n, rd_err, n == e && !ok);
      end
      if (data_out !== (n >= e ? d : prev_data)) begin
        fails++;
        $display("FAIL %s data_out edge %0d: got %h want %h", name, n, data_out, n >= e ? d : prev_data);
      end
      bus_in = n - 1 < 32 ? pat[n - 1] : 8'($urandom);
    end
    prev_data = d;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    tests += 3;
    if ({dev_en, busy, data_valid, rd_err} !== 7'b0 || data_out !== 8'h00) begin
      fails++;
      $display("FAIL reset outputs: got en=%b busy=%b dv=%b err=%b do=%h want all zero", dev_en, busy, data_valid, rd_err, data_out);
    end
    if ({dev_en3, busy3, data_valid3, rd_err3} !== 6'b0 || data_out3 !== 8'h00) begin
      fails++;
      $display("FAIL reset outputs n3: got en=%b busy=%b do=%h want zero", dev_en3, busy3, data_out3);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset idle busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single;
    foreach (pat[i]) pat[i] = 8'hA5;
    run_read(2'd2, 1'b0, "single");
  endtask

  task automatic test_glitch;
    foreach (pat[i]) pat[i] = 8'h3C;
    pat[WC + 1] = 8'h3D;
    run_read(2'd1, 1'b0, "glitch");
  endtask

  task automatic test_floating;
    foreach (pat[i]) pat[i] = i % 2 == 0 ? 8'h00 : 8'hFF;
    run_read(2'd3, 1'b0, "floating");
  endtask

  task automatic test_busy_req;
    foreach (pat[i]) pat[i] = 8'h77;
    run_read(2'd0, 1'b1, "busy_req");
  endtask

  task automatic test_random;
    for (int r = 0; r < 10; r++) begin
      foreach (pat[i]) pat[i] = 8'($urandom);
      for (int k = 0; k <= MR; k++)
        if ($urandom_range(0, 2) == 0) pat[k * (WC + 2) + WC + 1] = pat[k * (WC + 2) + WC];
      run_read(2'($urandom_range(0, 3)), 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) begin
      foreach (pat[i]) pat[i] = 8'(8'h10 + r);
      run_read(2'(r), 1'b0, "back_to_back");
    end
  endtask

  task automatic test_illegal;
    @(negedge clk);
    rd_req3 = 1'b1;
    rd_dev3 = 2'd3;
    @(negedge clk);
    rd_req3 = 1'b0;
    tests += 2;
    if (dev_en3 !== 3'b000 || rd_err3 !== 1'b1 || data_valid3 !== 1'b0 || busy3 !== 1'b1) begin
      fails++;
      $display("FAIL illegal edge1: got en=%b err=%b dv=%b busy=%b want 000 1 0 1", dev_en3, rd_err3, data_valid3, busy3);
    end
    @(negedge clk);
    if (dev_en3 !== 3'b000 || rd_err3 !== 1'b0 || busy3 !== 1'b0) begin
      fails++;
      $display("FAIL illegal edge2: got en=%b err=%b busy=%b want 000 0 0", dev_en3, rd_err3, busy3);
    end
  endtask

  task automatic test_reset_mid;
    foreach (pat[i]) pat[i] = 8'h5A;
    @(negedge clk);
    rd_req = 1'b1;
    rd_dev = 2'd3;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests += 2;
    if (dev_en !== 4'b1000) begin
      fails++;
      $display("FAIL reset_mid pre: dev_en got %b want 1000", dev_en);
    end
    #1 rst_n = 1'b0;
    #1;
    if ({dev_en, busy, data_valid, rd_err} !== 7'b0 || data_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid async: got en=%b busy=%b dv=%b err=%b do=%h want all zero", dev_en, busy, data_valid, rd_err, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_data = '0;
    run_read(2'd3, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_single;
    test_glitch;
    test_floating;
    test_busy_req;
    test_random;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tristate_bus_reader.md
Name: tristate_bus_reader

Overview:
- Read-side controller for the shared tri-state data bus.
- Bus drivers on this bus are combinational blocks that drive the bus only while their active-high enable is asserted, and release it to high-Z otherwise.
- This block selects one driver, waits for the bus to settle, double-samples the bus, and hands a stable word to the requester with a one-cycle valid pulse.
- If the two samples disagree (undriven or floating bus), the block retries; after too many retries it flags an error.

Parameters:
- WIDTH, 8, data bus width in bits.
- N_DEV, 4, number of tri-state drivers on the bus (one enable each).
- WAIT_CYCLES, 2, settle cycles after enable before first sample; legal range is 1 or more.
- MAX_RETRY, 3, number of sample-mismatch retries allowed before error; legal range is 0 or more.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_req  input  1  read request; sampled only in IDLE.
- rd_dev  input  $clog2(N_DEV)  index of the device to read; captured together with rd_req.
- bus_in  input  WIDTH  shared tri-state bus as seen by this block.
- dev_en  output  N_DEV  one-hot driver enables; all zero when not reading.
- busy  output  1  high in every state except IDLE.
- data_out  output  WIDTH  last successfully read word; holds between reads.
- data_valid  output  1  one-cycle pulse when data_out updates.
- rd_err  output  1  one-cycle pulse on failed read.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - State = IDLE; dev_en=0, busy=0, data_out=0, data_valid=0, rd_err=0.
  - Retry and wait counters = 0.
  - A reset mid-read drops dev_en in the same instant; the read is abandoned with no pulse.
- All outputs are registered.
- States: IDLE, ENABLE, SAMPLE1, SAMPLE2, DONE, ERR.
- IDLE:
  - On rd_req=1, capture rd_dev and clear the retry counter.
  - rd_dev < N_DEV: go to ENABLE.
  - rd_dev >= N_DEV: go to ERR, with dev_en never asserted.
  - rd_req while busy=1 is ignored; it is not queued.
- ENABLE:
  - dev_en[dev]=1; stay WAIT_CYCLES cycles, counted by the wait counter; then go to SAMPLE1.
- SAMPLE1: dev_en held; s1 <= bus_in; go to SAMPLE2.
- SAMPLE2: dev_en held; compare bus_in with s1 (full WIDTH).
  - Equal: data_out <= s1; go to DONE.
  - Unequal and retry < MAX_RETRY: retry++; go to ENABLE, reloading the wait counter, with dev_en kept asserted.
  - Unequal and retry == MAX_RETRY: go to ERR; data_out unchanged.
- DONE: dev_en=0, data_valid=1 for exactly this cycle; go to IDLE.
- ERR: dev_en=0, rd_err=1 for exactly this cycle; go to IDLE.
- data_valid and rd_err are never both high.
- At most one dev_en bit is high at any time.
- Latency, counted from the clk edge that accepts rd_req:
  - dev_en rises after 1 edge.
  - data_valid is high in the cycle after edge WAIT_CYCLES+3, i.e. edge 5 at the defaults.
  - Each retry adds WAIT_CYCLES+2 cycles.
- Back-to-back reads: a new rd_req can be accepted in the IDLE cycle directly after DONE/ERR. The minimum gap between accepted requests is WAIT_CYCLES+4 cycles.

Test Plan:
1. Reset then single read. rd_dev=2 with bus_in held at 8'hA5 while dev_en=4'b0100 -> dev_en=4'b0100 for 4 cycles; data_valid pulse at edge 5; data_out=8'hA5; busy back to 0 at edge 6.
2. One glitch. bus_in=8'h3C in SAMPLE1 and 8'h3D in the first SAMPLE2, then stable 8'h3C -> one retry; data_valid at edge 9; data_out=8'h3C; rd_err never asserted.
3. Floating bus. bus_in toggles every cycle (8'h00/8'hFF) -> 3 retries, then rd_err pulse at edge 17; data_out keeps its previous value; data_valid stays 0.
4. Illegal device. With N_DEV=3, rd_dev=3 -> dev_en stays 0; rd_err pulse at edge 1; back to IDLE.
5. Request while busy. Second rd_req (rd_dev=1) during the read of device 0 -> ignored; only dev_en[0] is ever asserted; exactly one data_valid pulse.
6. Reset mid-read. rst_n=0 asynchronously during SAMPLE1 -> dev_en=0, busy=0, data_out=0 without waiting for clk; no pulses; the next read after release completes normally.
